// File: rtl/pipe_perf_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : perf_pkg
// Purpose  : Shared definitions for the pipeline performance counter:
//            shadow-register read indices and the snapshot FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Read index of each shadow register on sel_i
    localparam logic [1:0] SEL_CYCLE  = 2'd0;
    localparam logic [1:0] SEL_STALL  = 2'd1;
    localparam logic [1:0] SEL_FLUSH  = 2'd2;
    localparam logic [1:0] SEL_RETIRE = 2'd3;

    // Snapshot request/acknowledge handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } snap_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_perf_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_perf_counter_if
// Purpose  : Snapshot handshake and shadow read-out bus of the counter block.
//   snap_req_i : snapshot request level, held until acknowledged
//   sel_i      : shadow-register read index
//   snap_ack_o : one-cycle snapshot acknowledge
//   rdata_o    : selected shadow register
//   master = requester / reader, slave = counter block
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_perf_counter_if #(
    parameter int WIDTH = 32
);
    logic             snap_req_i;
    logic [1:0]       sel_i;
    logic             snap_ack_o;
    logic [WIDTH-1:0] rdata_o;

    modport master (output snap_req_i, output sel_i, input snap_ack_o, input rdata_o);
    modport slave  (input snap_req_i, input sel_i, output snap_ack_o, output rdata_o);
endinterface
`default_nettype wire

// File: rtl/pipe_perf_counter_cell.sv
`default_nettype none
// ============================================================================
// Module   : perf_counter_cell
// Purpose  : One live event counter plus its snapshot shadow register.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   i_inc        : qualified event for this cycle
//   i_en         : count enable
//   i_clear      : synchronous clear of the live count (wins over i_inc)
//   i_capture    : load shadow with the value the live count takes this edge
//   o_live       : live count
//   o_shadow     : frozen snapshot value
//   o_wrap       : high when the live count rolls over at this edge
// Revision : 1.0 - initial release
// ============================================================================
module perf_counter_cell #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             i_inc,
    input  wire logic             i_en,
    input  wire logic             i_clear,
    input  wire logic             i_capture,
    output logic      [WIDTH-1:0] o_live,
    output logic      [WIDTH-1:0] o_shadow,
    output logic                  o_wrap
);
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_live;
    logic [WIDTH-1:0] r_shadow;
    logic [WIDTH-1:0] w_next;
    logic             w_step;

    assign w_step = i_en & i_inc & ~i_clear;
    assign w_next = i_clear ? '0 : (w_step ? r_live + c_one : r_live);
    assign o_wrap = w_step & (&r_live);

    // The shadow takes w_next, not r_live, so the capturing cycle's own
    // increment (or clear) is part of the snapshot.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_live   <= '0;
            r_shadow <= '0;
        end else begin
            r_live <= w_next;
            if (i_capture) begin
                r_shadow <= w_next;
            end
        end
    end

    assign o_live   = r_live;
    assign o_shadow = r_shadow;

endmodule
`default_nettype wire

// File: rtl/pipe_perf_counter.sv
`default_nettype none
// ============================================================================
// Module   : pipe_perf_counter
// Purpose  : Pipeline performance counters (cycles, load-use stalls, branch
//            flushes, retired instructions) with atomic snapshot and indexed
//            read-out of the frozen values.
//   clk_i, rst_i : clock, asynchronous active-low reset
//   en_i         : count enable
//   clear_i      : synchronous clear of live counters and ovf_o
//   stall_i      : hazard stall request
//   branch_i     : branch in ID (a stall with a branch is not a load-use stall)
//   flush_i      : branch flush
//   retire_i     : instruction retired from MEM/WB
//   snap_if      : snapshot request/ack and shadow read bus (slave side)
//   ovf_o        : sticky wrap flag of the live counters
// Revision : 1.0 - initial release
// ============================================================================
module pipe_perf_counter
    import perf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic          en_i,
    input  wire logic          clear_i,
    input  wire logic          stall_i,
    input  wire logic          branch_i,
    input  wire logic          flush_i,
    input  wire logic          retire_i,
    pipe_perf_counter_if.slave snap_if,
    output logic               ovf_o
);
    snap_state_t      r_state;
    logic             r_ack;
    logic             r_ovf;
    logic             w_capture;
    logic [3:0]       w_inc;
    logic [3:0]       w_wrap;
    logic [WIDTH-1:0] w_shadow      [4];
    logic [WIDTH-1:0] w_live_unused [4];
    logic [WIDTH-1:0] w_rdata;

    // Bit order follows the SEL_* read indices.
    assign w_inc = {retire_i, flush_i, stall_i & ~branch_i, 1'b1};

    // Capture happens on the same edge the request is first seen in IDLE.
    assign w_capture = (r_state == IDLE) && snap_if.snap_req_i;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_cell
            perf_counter_cell #(.WIDTH(WIDTH)) u_cell (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .i_inc     (w_inc[k]),
                .i_en      (en_i),
                .i_clear   (clear_i),
                .i_capture (w_capture),
                .o_live    (w_live_unused[k]),
                .o_shadow  (w_shadow[k]),
                .o_wrap    (w_wrap[k])
            );
        end
    endgenerate

    // A request held through ACK/WAIT must drop before it can re-arm.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (snap_if.snap_req_i) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                    end
                end
                ACK: begin
                    r_state <= WAIT;
                    r_ack   <= 1'b0;
                end
                WAIT: begin
                    r_ack <= 1'b0;
                    if (!snap_if.snap_req_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ovf <= 1'b0;
        end else if (clear_i) begin
            r_ovf <= 1'b0;
        end else if (|w_wrap) begin
            r_ovf <= 1'b1;
        end
    end

    always_comb begin
        w_rdata = w_shadow[0];
        case (snap_if.sel_i)
            SEL_CYCLE:  w_rdata = w_shadow[0];
            SEL_STALL:  w_rdata = w_shadow[1];
            SEL_FLUSH:  w_rdata = w_shadow[2];
            SEL_RETIRE: w_rdata = w_shadow[3];
            default:    w_rdata = w_shadow[0];
        endcase
    end

    assign snap_if.snap_ack_o = r_ack;
    assign snap_if.rdata_o    = w_rdata;
    assign ovf_o              = r_ovf;

endmodule
`default_nettype wire

// File: doc/pipe_perf_counter.md
# pipe_perf_counter

Hardware performance-counter block attached to the pipelined CPU, downstream of the hazard-detection, branch and MEM/WB stages. Each cycle it counts total cycles, load-use stalls (stall not caused by a branch), branch flushes and retired instructions. Software or the bench can freeze all four counts atomically into shadow registers through a request/acknowledge handshake and then read them out one at a time by index.

## Interface
- WIDTH, 32, width of every counter and of rdata_o
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  asynchronous, active-low reset
- en_i  input  1  count enable; when 0, live counters hold
- clear_i  input  1  synchronous clear of the live counters and ovf_o
- stall_i  input  1  hazard-detection stall request
- branch_i  input  1  control-unit branch indication for the ID-stage instruction
- flush_i  input  1  branch-unit flush
- retire_i  input  1  an instruction leaves MEM/WB with a valid write-back or store
- snap_req_i  input  1  snapshot request; level, held until acknowledged
- sel_i  input  2  shadow-register read index
- snap_ack_o  output  1  snapshot acknowledge, one-cycle pulse
- rdata_o  output  WIDTH  selected shadow register
- ovf_o  output  1  sticky flag: some live counter wrapped

## Operation
- Live counters cyc, stl, fls, ret increment by 1 at each edge when en_i=1:
  - cyc: unconditionally.
  - stl: when stall_i=1 and branch_i=0.
  - fls: when flush_i=1.
  - ret: when retire_i=1.
- Arithmetic is modulo 2^WIDTH. A wrap from all-ones to 0 sets ovf_o at the same edge.
- clear_i=1 loads 0 into all live counters and ovf_o at the next edge, overriding any increment in that cycle. Shadow registers are not affected.
- Snapshot FSM, 3 states:
  - IDLE: snap_req_i=1 → capture, go to ACK.
  - ACK: snap_ack_o=1; go to WAIT unconditionally.
  - WAIT: snap_req_i=0 → IDLE; otherwise stay.
- Capture loads each shadow register with the value its live counter takes at that same edge, so the capturing cycle's increment is included. If clear_i is also high, the shadows capture 0.
- A request held high through ACK and WAIT does not trigger a second capture. A new capture needs snap_req_i low for at least one cycle in WAIT or IDLE.
- rdata_o is combinational from the shadow registers: sel 0 = cyc, 1 = stl, 2 = fls, 3 = ret.

## Timing
- Reset (rst_i=0), asynchronous, takes effect immediately:
  - all live and shadow counters = 0;
  - ovf_o = 0, snap_ack_o = 0;
  - FSM = IDLE;
  - rdata_o = 0.
- Reset asserted in ACK or WAIT aborts the handshake. snap_ack_o drops without waiting for a clock.
- Snapshot latency: request seen at edge N → capture at edge N, snap_ack_o high from edge N to edge N+1 (exactly one cycle).
- Minimum spacing between two captures is 3 cycles: req, ack, req low in WAIT.
- en_i=0 freezes the live counters, but the FSM, capture and clear stay active.
- The first edge after rst_i deasserts counts normally; there is no dead cycle.

## Structure
- Shared package perf_pkg holds:
  - the sel encodings SEL_CYCLE=0, SEL_STALL=1, SEL_FLUSH=2, SEL_RETIRE=3;
  - the snapshot FSM state enum (IDLE, ACK, WAIT).
- Sub-module perf_counter_cell is instantiated four times. It contains one WIDTH-bit live counter plus its shadow register.
  - Inputs: inc, en, clear, capture.
  - Outputs: live value, shadow value, wrap pulse.
- The top level contains the increment qualification, the FSM, the ovf OR-reduction and the read mux.

## Test plan
- Reset then 10 cycles with en_i=1, stall_i=1 and branch_i=1 on cycles 3–4, stall_i=1 alone on cycles 6–7, flush_i on cycle 4, retire_i on 5 cycles, then snapshot → shadows cyc=11 (10 + capture cycle), stl=2, fls=1, ret=5; snap_ack_o high exactly one cycle after the capture edge.
- Hold snap_req_i high for 6 cycles → exactly one snap_ack_o pulse and a single capture. Drop the request, reassert it → a second pulse, and the shadows now hold later values.
- Force cyc to 32'hFFFF_FFFE, count 2 cycles → cyc=0 and ovf_o=1. Assert clear_i → ovf_o=0 and all live counters 0 while the shadows keep their values.
- clear_i and snap_req_i high in the same cycle → all four shadows read 0 through sel_i 0..3.
- en_i=0 for 5 cycles with all events high, then snapshot → counts unchanged from the pre-disable values, except the capture-cycle increment if en_i is back to 1.
- Assert rst_i low mid-ACK (asynchronously, between edges) → snap_ack_o, rdata_o and ovf_o drop to 0 immediately, the FSM returns to IDLE, and the next request is handled normally.
